pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard controller for a classic 5-stage pipeline. Produces the same-cycle
// pipeline-register controls for three hazards:
//   - load-use: the ID/EX load writes a register that IF/ID reads. The front
//     end holds for one cycle and a bubble is sent into ID/EX.
//   - taken branch/jump resolved in ID: the wrong-path IF/ID entry is flushed.
//   - multi-cycle data memory: the whole pipe freezes for MEM_LAT+1 cycles.
//     A branch seen during the freeze is remembered and its flush is issued
//     in a single FLUSH_PEND cycle after the wait.
//
// There is no valid/ready handshake here. All outputs are combinational
// functions of the current state and inputs. They are meant to be consumed in
// the same cycle.
//
// Parameters
//   MEM_LAT         data-memory wait cycles, legal range 1..15
//
// Ports
//   clk_i           clock, all state updates on posedge
//   rst_i           asynchronous active-high reset
//   idex_memread_i  instruction in ID/EX is a load
//   idex_rt_i       load destination register in ID/EX
//   ifid_rs_i       source register rs of the instruction in IF/ID
//   ifid_rt_i       source register rt of the instruction in IF/ID
//   branch_taken_i  branch/jump resolved taken in ID this cycle
//   mem_start_i     multi-cycle data-memory access begins this cycle
//   pc_write_o      1 = PC loads its next value
//   ifid_write_o    1 = IF/ID loads, 0 = IF/ID holds
//   ifid_flush_o    1 = IF/ID clears to 0
//   idex_bubble_o   1 = ID/EX control fields forced to 0
//   freeze_o        1 = EX/MEM and MEM/WB hold
//   busy_o          controller state is not RUN
//   stall_cnt_o     saturating count of stall cycles
//   flush_cnt_o     saturating count of issued flushes
//   dbg_state_o     current FSM state (0 RUN, 1 MEM_WAIT, 2 FLUSH_PEND)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_LAT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        idex_memread_i,
  input  logic [4:0]  idex_rt_i,
  input  logic [4:0]  ifid_rs_i,
  input  logic [4:0]  ifid_rt_i,
  input  logic        branch_taken_i,
  input  logic        mem_start_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic        freeze_o,
  output logic        busy_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MEM_WAIT   = 2'd1,
    ST_FLUSH_PEND = 2'd2
  } state_t;

  // The start cycle is the first frozen cycle. MEM_WAIT therefore runs for
  // MEM_LAT cycles, with wcnt counting MEM_LAT-1 down to 0.
  localparam logic [3:0] LP_WAIT_INIT = 4'(MEM_LAT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_wcnt;
  logic [3:0]  w_wcnt_nxt;
  logic        r_pend;
  logic        w_pend_nxt;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;
  logic        w_load_use;
  logic        w_stall_inc;
  logic        w_flush_inc;
  logic        w_pend_or_br;

  // Register 0 is hardwired to zero, so a load targeting it cannot create a
  // hazard.
  assign w_load_use = idex_memread_i & (idex_rt_i != 5'd0) &
                      ((idex_rt_i == ifid_rs_i) | (idex_rt_i == ifid_rt_i));

  // A branch in the last wait cycle still has to be honoured. The exit
  // decision therefore looks at the live input as well as the flag.
  assign w_pend_or_br = r_pend | branch_taken_i;

  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    freeze_o      = 1'b0;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;
    w_state_nxt   = r_state;
    w_wcnt_nxt    = r_wcnt;
    w_pend_nxt    = r_pend;

    // While reset is high, the outputs stay at the RUN defaults. The state
    // registers are already held in reset during this time.
    if (!rst_i) begin
      case (r_state)
        ST_RUN: begin
          if (mem_start_i) begin
            // The memory freeze wins. A simultaneous branch is deferred and
            // a simultaneous load-use is covered by the freeze itself.
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            freeze_o     = 1'b1;
            w_state_nxt  = ST_MEM_WAIT;
            w_wcnt_nxt   = LP_WAIT_INIT;
            w_pend_nxt   = branch_taken_i;
          end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
            w_flush_inc  = 1'b1;
          end else if (w_load_use) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
            w_stall_inc   = 1'b1;
          end
        end

        ST_MEM_WAIT: begin
          pc_write_o   = 1'b0;
          ifid_write_o = 1'b0;
          freeze_o     = 1'b1;
          w_stall_inc  = 1'b1;
          w_pend_nxt   = w_pend_or_br;
          if (r_wcnt == 4'd0) begin
            w_state_nxt = w_pend_or_br ? ST_FLUSH_PEND : ST_RUN;
          end else begin
            w_wcnt_nxt = r_wcnt - 4'd1;
          end
        end

        ST_FLUSH_PEND: begin
          // The IF/ID write enable stays at 1 in this cycle so that a flush
          // never coincides with a hold.
          ifid_flush_o = 1'b1;
          w_flush_inc  = 1'b1;
          w_pend_nxt   = 1'b0;
          w_state_nxt  = ST_RUN;
        end

        default: begin
          w_state_nxt = ST_RUN;
          w_pend_nxt  = 1'b0;
          w_wcnt_nxt  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_RUN;
      r_wcnt      <= 4'd0;
      r_pend      <= 1'b0;
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_pend  <= w_pend_nxt;
      // The counters saturate at all ones instead of wrapping.
      if (w_stall_inc && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (w_flush_inc && (r_flush_cnt != 16'hFFFF)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign busy_o      = (r_state != ST_RUN);
  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int MEM_LAT = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        idex_memread_i = 1'b0;
  logic [4:0]  idex_rt_i = 5'd0;
  logic [4:0]  ifid_rs_i = 5'd0;
  logic [4:0]  ifid_rt_i = 5'd0;
  logic        branch_taken_i = 1'b0;
  logic        mem_start_i = 1'b0;
  logic        pc_write_o;
  logic        ifid_write_o;
  logic        ifid_flush_o;
  logic        idex_bubble_o;
  logic        freeze_o;
  logic        busy_o;
  logic [15:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;
  logic [1:0]  dbg_state_o;

  always #5 clk_i = ~clk_i;

  pipe_hazard_ctrl #(.MEM_LAT(MEM_LAT)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .idex_memread_i (idex_memread_i),
    .idex_rt_i      (idex_rt_i),
    .ifid_rs_i      (ifid_rs_i),
    .ifid_rt_i      (ifid_rt_i),
    .branch_taken_i (branch_taken_i),
    .mem_start_i    (mem_start_i),
    .pc_write_o     (pc_write_o),
    .ifid_write_o   (ifid_write_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_bubble_o  (idex_bubble_o),
    .freeze_o       (freeze_o),
    .busy_o         (busy_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o),
    .dbg_state_o    (dbg_state_o)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and check helpers
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. The freeze is tracked as a count of the wait cycles
  // still owed, together with "flush owed next cycle" and "branch seen while
  // frozen". The counters are plain saturating integers.
  // ---------------------------------------------------------------------------
  int m_wait_left   = 0;
  bit m_flush_now   = 1'b0;
  bit m_branch_seen = 1'b0;
  int m_stall       = 0;
  int m_flush       = 0;

  function automatic bit m_load_use();
    return idex_memread_i && (idex_rt_i != 5'd0) &&
           ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_wait_left   = 0;
      m_flush_now   = 1'b0;
      m_branch_seen = 1'b0;
      m_stall       = 0;
      m_flush       = 0;
    end else if (m_flush_now) begin
      if (m_flush < 65535) m_flush++;
      m_flush_now = 1'b0;
    end else if (m_wait_left > 0) begin
      if (m_stall < 65535) m_stall++;
      if (branch_taken_i) m_branch_seen = 1'b1;
      m_wait_left--;
      if (m_wait_left == 0) begin
        m_flush_now   = m_branch_seen;
        m_branch_seen = 1'b0;
      end
    end else if (mem_start_i) begin
      m_wait_left   = MEM_LAT;
      m_branch_seen = branch_taken_i;
    end else if (branch_taken_i) begin
      if (m_flush < 65535) m_flush++;
    end else if (m_load_use()) begin
      if (m_stall < 65535) m_stall++;
    end
  end

  // This process compares the DUT against the model in every cycle. The
  // inputs change on the falling edge and settle by +2.
  always @(negedge clk_i) begin
    logic e_pc, e_ifw, e_fl, e_bub, e_frz, e_busy;
    #2;
    e_pc = 1'b1; e_ifw = 1'b1; e_fl = 1'b0; e_bub = 1'b0; e_frz = 1'b0;
    e_busy = (m_wait_left > 0) || m_flush_now;
    if (rst_i) begin
      e_busy = 1'b0;
    end else if (m_flush_now) begin
      e_fl = 1'b1;
    end else if (m_wait_left > 0 || mem_start_i) begin
      e_pc = 1'b0; e_ifw = 1'b0; e_frz = 1'b1;
    end else if (branch_taken_i) begin
      e_fl = 1'b1;
    end else if (m_load_use()) begin
      e_pc = 1'b0; e_ifw = 1'b0; e_bub = 1'b1;
    end
    check1("model_pc_write", pc_write_o, e_pc);
    check1("model_ifid_write", ifid_write_o, e_ifw);
    check1("model_ifid_flush", ifid_flush_o, e_fl);
    check1("model_idex_bubble", idex_bubble_o, e_bub);
    check1("model_freeze", freeze_o, e_frz);
    check1("model_busy", busy_o, e_busy);
    check16("model_stall_cnt", stall_cnt_o, 16'(m_stall));
    check16("model_flush_cnt", flush_cnt_o, 16'(m_flush));
    // A flush must never coincide with an IF/ID hold.
    check1("flush_without_hold", ifid_flush_o & ~ifid_write_o, 1'b0);
  end

  // ---------------------------------------------------------------------------
  // Driver tasks: inputs change on the falling edge. Directed checks run at
  // +3, which is after the compare process and before the next rising edge.
  // ---------------------------------------------------------------------------
  task automatic apply(input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                       input logic [4:0] rtt, input logic br, input logic ms);
    @(negedge clk_i);
    idex_memread_i = mr;
    idex_rt_i      = rt;
    ifid_rs_i      = rs;
    ifid_rt_i      = rtt;
    branch_taken_i = br;
    mem_start_i    = ms;
    #3;
  endtask

  task automatic idle();
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  // Applies a mem_start pulse, then counts frozen and busy cycles over a
  // window longer than the freeze.
  task automatic mem_wait_check(input int stall_before);
    int n_freeze;
    int n_busy;
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    check1("mw_start_freeze", freeze_o, 1'b1);
    check1("mw_start_busy", busy_o, 1'b0);
    n_freeze = 1;
    n_busy   = 0;
    for (int i = 0; i < 7; i++) begin
      idle();
      if (freeze_o) n_freeze++;
      if (busy_o) n_busy++;
    end
    check16("mw_freeze_cycles", 16'(n_freeze), 16'd5);
    check16("mw_busy_cycles", 16'(n_busy), 16'd4);
    check16("mw_stall_cnt", stall_cnt_o, 16'(stall_before + 4));
    check1("mw_after_pc_write", pc_write_o, 1'b1);
    check1("mw_after_flush", ifid_flush_o, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus with hand-computed literals
  // ---------------------------------------------------------------------------
  initial begin
    // While reset is high, the outputs are the RUN defaults even with events on the inputs.
    idle();
    check1("rst_pc_write", pc_write_o, 1'b1);
    check1("rst_busy", busy_o, 1'b0);
    check16("rst_stall_cnt", stall_cnt_o, 16'd0);
    check16("rst_flush_cnt", flush_cnt_o, 16'd0);
    apply(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1);
    check1("rst_ignore_freeze", freeze_o, 1'b0);
    check1("rst_ignore_flush", ifid_flush_o, 1'b0);
    check1("rst_ignore_bubble", idex_bubble_o, 1'b0);
    idle();
    check1("rst_ignore_busy", busy_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Load-use through rs, then through rt.
    apply(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    check1("lu_pc_write", pc_write_o, 1'b0);
    check1("lu_ifid_write", ifid_write_o, 1'b0);
    check1("lu_bubble", idex_bubble_o, 1'b1);
    idle();
    check16("lu_stall_cnt_1", stall_cnt_o, 16'd1);
    check1("lu_release", pc_write_o, 1'b1);
    apply(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0);
    check1("lu_rt_bubble", idex_bubble_o, 1'b1);
    // r0 destination and non-load cases produce no stall.
    apply(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    check1("lu_r0_bubble", idex_bubble_o, 1'b0);
    check1("lu_r0_pc_write", pc_write_o, 1'b1);
    apply(1'b0, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0);
    check1("lu_noload_bubble", idex_bubble_o, 1'b0);
    check16("lu_stall_cnt_2", stall_cnt_o, 16'd2);

    // Taken branch in RUN, with a load-use present that it outranks.
    apply(1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0);
    check1("br_flush", ifid_flush_o, 1'b1);
    check1("br_busy", busy_o, 1'b0);
    check1("br_no_bubble", idex_bubble_o, 1'b0);
    idle();
    check16("br_flush_cnt", flush_cnt_o, 16'd1);
    check16("br_stall_cnt", stall_cnt_o, 16'd2);

    // Basic memory wait.
    mem_wait_check(2);

    // Branch in the 2nd wait cycle, then a load-use in FLUSH_PEND that is ignored.
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    idle();
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    check1("bw_wait_flush", ifid_flush_o, 1'b0);
    check1("bw_wait_freeze", freeze_o, 1'b1);
    idle();
    idle();
    apply(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    check1("bw_fp_flush", ifid_flush_o, 1'b1);
    check1("bw_fp_pc_write", pc_write_o, 1'b1);
    check1("bw_fp_ifid_write", ifid_write_o, 1'b1);
    check1("bw_fp_bubble", idex_bubble_o, 1'b0);
    check1("bw_fp_busy", busy_o, 1'b1);
    check1("bw_fp_freeze", freeze_o, 1'b0);
    idle();
    check1("bw_run_busy", busy_o, 1'b0);
    check16("bw_flush_cnt", flush_cnt_o, 16'd2);
    check16("bw_stall_cnt", stall_cnt_o, 16'd10);

    // A branch in the final wait cycle still produces the deferred flush.
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    idle();
    idle();
    idle();
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    check1("bl_wait_freeze", freeze_o, 1'b1);
    idle();
    check1("bl_fp_flush", ifid_flush_o, 1'b1);
    idle();
    check16("bl_flush_cnt", flush_cnt_o, 16'd3);
    check16("bl_stall_cnt", stall_cnt_o, 16'd14);

    // mem_start, branch and load-use all arrive together.
    apply(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1);
    check1("all_freeze", freeze_o, 1'b1);
    check1("all_no_bubble", idex_bubble_o, 1'b0);
    check1("all_no_flush", ifid_flush_o, 1'b0);
    for (int i = 0; i < MEM_LAT; i++) idle();
    idle();
    check1("all_fp_flush", ifid_flush_o, 1'b1);
    idle();
    check16("all_flush_cnt", flush_cnt_o, 16'd4);
    check16("all_stall_cnt", stall_cnt_o, 16'd18);

    // Mixed sequence checked by the model: mem_start during a wait,
    // back-to-back freezes, and a load-use right after a wait.
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    apply(1'b1, 5'd3, 5'd3, 5'd3, 1'b0, 1'b1);
    idle();
    idle();
    apply(1'b1, 5'd6, 5'd1, 5'd6, 1'b0, 1'b0);
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    idle();
    idle();
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    idle();

    // Asynchronous reset in the middle of a wait, between clock edges.
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    idle();
    idle();
    check1("ar_pre_busy", busy_o, 1'b1);
    rst_i = 1'b1;
    #1;
    check1("ar_busy", busy_o, 1'b0);
    check1("ar_freeze", freeze_o, 1'b0);
    check1("ar_pc_write", pc_write_o, 1'b1);
    check16("ar_stall_cnt", stall_cnt_o, 16'd0);
    check16("ar_flush_cnt", flush_cnt_o, 16'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    mem_wait_check(0);
    idle();
    check16("ar_no_stale_flush", flush_cnt_o, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
